decode_stage: RTL and testbench

- Second stage of the 5-stage pipeline, directly downstream of fetch; consumes InstrD/PCPlus4D registered by fetch.
- Decodes the instruction, reads/writes the 32x32 register file, resolves branches/jumps early, and drives PCSrcD/PCBranchD back to fetch.
- Owns the D/E pipeline register that feeds execute; supports a stall qualifier and an execute flush from the hazard unit.

---
 rtl/decode_stage_pkg.sv | 108 ++++++++++
 rtl/decode_stage_if.sv | 28 ++
 rtl/decode_stage_reg_file.sv | 40 ++++
 rtl/decode_stage.sv | 125 ++++++++++++
 tb/tb_decode_stage.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode constants: opcode/funct fields, ALU control encodings and the
// decoded control bundle, plus the opcode/funct to control decoder.
package decode_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_LUI = 4'b1000,
        ALU_NOR = 4'b1100
    } alu_ctrl_t;

    typedef struct packed {
        logic      reg_write;
        logic      mem_to_reg;
        logic      mem_write;
        logic      alu_src;
        logic      reg_dst;
        logic      branch_eq;
        logic      branch_ne;
        logic      jump;
        logic      zero_ext;
        alu_ctrl_t alu_ctrl;
    } ctrl_t;

    // NOP and bubble share one encoding: nothing written, nothing redirected.
    localparam ctrl_t CTRL_NOP = '{
        reg_write: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, alu_src: 1'b0,
        reg_dst: 1'b0, branch_eq: 1'b0, branch_ne: 1'b0, jump: 1'b0,
        zero_ext: 1'b0, alu_ctrl: ALU_AND
    };

    function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                case (funct)
                    F_ADD:   c.alu_ctrl = ALU_ADD;
                    F_SUB:   c.alu_ctrl = ALU_SUB;
                    F_AND:   c.alu_ctrl = ALU_AND;
                    F_OR:    c.alu_ctrl = ALU_OR;
                    F_NOR:   c.alu_ctrl = ALU_NOR;
                    F_SLT:   c.alu_ctrl = ALU_SLT;
                    default: c = CTRL_NOP;
                endcase
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = ALU_ADD;
            end
            OP_BEQ: begin
                c.branch_eq = 1'b1;
                c.alu_ctrl  = ALU_SUB;
            end
            OP_BNE: begin
                c.branch_ne = 1'b1;
                c.alu_ctrl  = ALU_SUB;
            end
            OP_ADDI, OP_SLTI, OP_LUI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = (op == OP_ADDI) ? ALU_ADD :
                              (op == OP_SLTI) ? ALU_SLT : ALU_LUI;
            end
            OP_ANDI, OP_ORI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.zero_ext  = 1'b1;
                c.alu_ctrl  = (op == OP_ANDI) ? ALU_AND : ALU_OR;
            end
            OP_J:    c.jump = 1'b1;
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-to-execute pipeline register bundle; decode drives it as master,
// execute consumes it as slave.
interface decode_stage_if #(
    parameter int DATA_W = 32
);
    logic              RegWriteE;
    logic              MemtoRegE;
    logic              MemWriteE;
    logic              ALUSrcE;
    logic              RegDstE;
    logic [3:0]        ALUControlE;
    logic [DATA_W-1:0] RD1E;
    logic [DATA_W-1:0] RD2E;
    logic [DATA_W-1:0] SignImmE;
    logic [4:0]        RsE;
    logic [4:0]        RtE;
    logic [4:0]        RdE;

    modport master (
        output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
               RD1E, RD2E, SignImmE, RsE, RtE, RdE
    );

    modport slave (
        input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
               RD1E, RD2E, SignImmE, RsE, RtE, RdE
    );
endinterface

// File: rtl/decode_stage_reg_file.sv
// Register file: two combinational read ports with same-cycle writeback
// bypass, one write port, r0 hardwired to zero, synchronous clear.
module decode_stage_reg_file #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [$clog2(NREG)-1:0] i_ra1,
    input  logic [$clog2(NREG)-1:0] i_ra2,
    output logic [DATA_W-1:0]       o_rd1,
    output logic [DATA_W-1:0]       o_rd2,
    input  logic                    i_we,
    input  logic [$clog2(NREG)-1:0] i_wa,
    input  logic [DATA_W-1:0]       i_wd
);
    logic [DATA_W-1:0] r_regs [NREG];
    logic              w_wr_valid;

    assign w_wr_valid = i_we && (i_wa != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    always_comb begin
        o_rd1 = r_regs[i_ra1];
        o_rd2 = r_regs[i_ra2];
        if (w_wr_valid && (i_wa == i_ra1)) o_rd1 = i_wd;
        if (w_wr_valid && (i_wa == i_ra2)) o_rd2 = i_wd;
        if (i_ra1 == '0) o_rd1 = '0;
        if (i_ra2 == '0) o_rd2 = '0;
    end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction decode, register file access, early branch/jump
// resolution back to fetch, and the D/E pipeline register.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int PC_W   = 9,
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       InstrD,
    input  logic [PC_W-1:0]   PCPlus4D,
    input  logic              StallD,
    input  logic              FlushE,
    input  logic              ForwardAD,
    input  logic              ForwardBD,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic              RegWriteW,
    input  logic [4:0]        WriteRegW,
    input  logic [DATA_W-1:0] ResultW,
    output logic              PCSrcD,
    output logic [PC_W-1:0]   PCBranchD,
    output logic [4:0]        RsD,
    output logic [4:0]        RtD,
    output logic              BranchD,
    decode_stage_if.master    de
);
    ctrl_t             w_ctrl;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_sign_imm;
    logic [DATA_W-1:0] w_cmp_a;
    logic [DATA_W-1:0] w_cmp_b;
    logic              w_equal;
    logic [4:0]        w_rd_idx;

    logic              r_reg_write, r_mem_to_reg, r_mem_write, r_alu_src, r_reg_dst;
    logic [3:0]        r_alu_ctrl;
    logic [DATA_W-1:0] r_rd1, r_rd2, r_sign_imm;
    logic [4:0]        r_rs, r_rt, r_rd;

    assign w_ctrl   = decode_ctrl(InstrD[31:26], InstrD[5:0]);
    assign RsD      = InstrD[25:21];
    assign RtD      = InstrD[20:16];
    assign w_rd_idx = InstrD[15:11];
    assign BranchD  = w_ctrl.branch_eq | w_ctrl.branch_ne;

    assign w_sign_imm = w_ctrl.zero_ext ? {{(DATA_W-16){1'b0}}, InstrD[15:0]}
                                        : {{(DATA_W-16){InstrD[15]}}, InstrD[15:0]};

    decode_stage_reg_file #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_reg_file (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra1 (RsD),
        .i_ra2 (RtD),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2),
        .i_we  (RegWriteW),
        .i_wa  (WriteRegW),
        .i_wd  (ResultW)
    );

    assign w_cmp_a = ForwardAD ? ALUOutM : w_rd1;
    assign w_cmp_b = ForwardBD ? ALUOutM : w_rd2;
    assign w_equal = (w_cmp_a == w_cmp_b);

    assign PCSrcD = ~StallD & ((w_ctrl.branch_eq & w_equal) |
                               (w_ctrl.branch_ne & ~w_equal) |
                               w_ctrl.jump);

    always_comb begin
        PCBranchD = PCPlus4D;
        if (BranchD)          PCBranchD = PCPlus4D + w_sign_imm[PC_W-1:0];
        else if (w_ctrl.jump) PCBranchD = InstrD[PC_W-1:0];
    end

    // Reset, flush and stall all load the same all-zero bubble, so the
    // reset > flush > stall > load priority collapses into one condition.
    always_ff @(posedge clk) begin
        if (!rst_n || FlushE || StallD) begin
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_alu_ctrl   <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_sign_imm   <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
        end else begin
            r_reg_write  <= w_ctrl.reg_write;
            r_mem_to_reg <= w_ctrl.mem_to_reg;
            r_mem_write  <= w_ctrl.mem_write;
            r_alu_src    <= w_ctrl.alu_src;
            r_reg_dst    <= w_ctrl.reg_dst;
            r_alu_ctrl   <= w_ctrl.alu_ctrl;
            r_rd1        <= w_rd1;
            r_rd2        <= w_rd2;
            r_sign_imm   <= w_sign_imm;
            r_rs         <= RsD;
            r_rt         <= RtD;
            r_rd         <= w_rd_idx;
        end
    end

    assign de.RegWriteE   = r_reg_write;
    assign de.MemtoRegE   = r_mem_to_reg;
    assign de.MemWriteE   = r_mem_write;
    assign de.ALUSrcE     = r_alu_src;
    assign de.RegDstE     = r_reg_dst;
    assign de.ALUControlE = r_alu_ctrl;
    assign de.RD1E        = r_rd1;
    assign de.RD2E        = r_rd2;
    assign de.SignImmE    = r_sign_imm;
    assign de.RsE         = r_rs;
    assign de.RtE         = r_rt;
    assign de.RdE         = r_rd;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected D/E contents are queued as each
// instruction is presented and popped after the following clock edge.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] InstrD;
    logic [8:0]  PCPlus4D;
    logic        StallD, FlushE, ForwardAD, ForwardBD;
    logic [31:0] ALUOutM;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        PCSrcD;
    logic [8:0]  PCBranchD;
    logic [4:0]  RsD, RtD;
    logic        BranchD;

    decode_stage_if #(.DATA_W(32)) de_if ();

    decode_stage #(
        .PC_W   (9),
        .DATA_W (32),
        .NREG   (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .StallD    (StallD),
        .FlushE    (FlushE),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .ALUOutM   (ALUOutM),
        .RegWriteW (RegWriteW),
        .WriteRegW (WriteRegW),
        .ResultW   (ResultW),
        .PCSrcD    (PCSrcD),
        .PCBranchD (PCBranchD),
        .RsD       (RsD),
        .RtD       (RtD),
        .BranchD   (BranchD),
        .de        (de_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, m2r, mw, asrc, rdst;
        logic [3:0]  aluc;
        logic [31:0] rd1, rd2, simm;
        logic [4:0]  rs, rt, rd;
    } e_t;

    localparam e_t BUBBLE = '0;

    e_t exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic e_t mk(input logic rw, m2r, mw, asrc, rdst, input logic [3:0] aluc,
                              input logic [31:0] rd1, rd2, simm, input logic [4:0] rs, rt, rd);
        return '{rw, m2r, mw, asrc, rdst, aluc, rd1, rd2, simm, rs, rt, rd};
    endfunction

    function automatic e_t obs_e();
        return '{de_if.RegWriteE, de_if.MemtoRegE, de_if.MemWriteE, de_if.ALUSrcE,
                 de_if.RegDstE, de_if.ALUControlE, de_if.RD1E, de_if.RD2E,
                 de_if.SignImmE, de_if.RsE, de_if.RtE, de_if.RdE};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick_and_check(input string tag);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e_t e;
            e = exp_q.pop_front();
            assert (obs_e() === e)
            else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs_e(), e);
            end
        end
    endtask

    task automatic idle();
        rst_n     = 1'b1;
        StallD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ALUOutM   = '0;
        RegWriteW = 1'b0;
        WriteRegW = '0;
        ResultW   = '0;
    endtask

    initial begin
        idle();
        InstrD   = '0;
        PCPlus4D = '0;

        // Reset with a pending writeback to r4: reset must win
        rst_n = 1'b0; RegWriteW = 1'b1; WriteRegW = 5'd4; ResultW = 32'h55;
        exp_q.push_back(BUBBLE);
        tick_and_check("reset_bubble");

        // add r2,r5,r4: r5 and r4 read 0 after reset
        idle();
        InstrD = rtype(5'd5, 5'd4, 5'd2, 6'h20); PCPlus4D = 9'h022;
        #1;
        chk("add_pcsrc", 32'(PCSrcD), 32'd0);
        chk("add_pcbranch", 32'(PCBranchD), 32'h022);
        chk("add_rsd", 32'(RsD), 32'd5);
        chk("add_rtd", 32'(RtD), 32'd4);
        exp_q.push_back(mk(1, 0, 0, 0, 1, 4'b0010, 0, 0, 32'h1020, 5, 4, 2));
        tick_and_check("add_after_reset");

        // Writeback bypass r3 = DEADBEEF while reading it
        RegWriteW = 1'b1; WriteRegW = 5'd3; ResultW = 32'hDEADBEEF;
        InstrD = rtype(5'd3, 5'd0, 5'd1, 6'h20);
        exp_q.push_back(mk(1, 0, 0, 0, 1, 4'b0010, 32'hDEADBEEF, 0, 32'h820, 3, 0, 1));
        tick_and_check("wb_bypass");

        // Write to r0 while reading it; r3 now from the array
        WriteRegW = 5'd0; ResultW = 32'h12345678;
        InstrD = rtype(5'd0, 5'd3, 5'd1, 6'h20);
        exp_q.push_back(mk(1, 0, 0, 0, 1, 4'b0010, 0, 32'hDEADBEEF, 32'h820, 0, 3, 1));
        tick_and_check("r0_write_bypass");

        // r0 still 0 after the write; r1 = 7 bypassed; sub
        WriteRegW = 5'd1; ResultW = 32'd7;
        InstrD = rtype(5'd0, 5'd1, 5'd5, 6'h22);
        exp_q.push_back(mk(1, 0, 0, 0, 1, 4'b0110, 0, 7, 32'h2822, 0, 1, 5));
        tick_and_check("r0_stays_zero_sub");

        // beq r1,r2,-4 with r2 = 7 bypassed, PC+1 = 5 -> target 1
        WriteRegW = 5'd2; ResultW = 32'd7;
        InstrD = itype(6'h04, 5'd1, 5'd2, 16'hFFFC); PCPlus4D = 9'h005;
        #1;
        chk("beq_taken_pcsrc", 32'(PCSrcD), 32'd1);
        chk("beq_taken_target", 32'(PCBranchD), 32'h001);
        chk("beq_branchd", 32'(BranchD), 32'd1);
        StallD = 1'b1;
        #1;
        chk("beq_stalled_pcsrc", 32'(PCSrcD), 32'd0);
        exp_q.push_back(BUBBLE);
        tick_and_check("stall_bubble");

        // Held beq re-decodes and loads into E
        idle();
        #1;
        chk("beq_redecode_pcsrc", 32'(PCSrcD), 32'd1);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 4'b0110, 7, 7, 32'hFFFFFFFC, 1, 2, 5'h1F));
        tick_and_check("beq_load");

        // bne r1,r2 with r2 = 9 bypassed; forwarding A from ALUOutM = 9
        RegWriteW = 1'b1; WriteRegW = 5'd2; ResultW = 32'd9;
        InstrD = itype(6'h05, 5'd1, 5'd2, 16'h0003); PCPlus4D = 9'h010;
        #1;
        chk("bne_nofwd_pcsrc", 32'(PCSrcD), 32'd1);
        chk("bne_target", 32'(PCBranchD), 32'h013);
        ForwardAD = 1'b1; ALUOutM = 32'd9;
        #1;
        chk("bne_fwd_pcsrc", 32'(PCSrcD), 32'd0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 4'b0110, 7, 9, 32'h3, 1, 2, 0));
        tick_and_check("bne_load_unforwarded");

        // beq r2,r2,+2 at PC+1 = 0x1FF wraps to 1; forward B breaks equality
        idle();
        InstrD = itype(6'h04, 5'd2, 5'd2, 16'h0002); PCPlus4D = 9'h1FF;
        #1;
        chk("beq_wrap_pcsrc", 32'(PCSrcD), 32'd1);
        chk("beq_wrap_target", 32'(PCBranchD), 32'h001);
        ForwardBD = 1'b1; ALUOutM = 32'd5;
        #1;
        chk("beq_fwdb_pcsrc", 32'(PCSrcD), 32'd0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 4'b0110, 9, 9, 32'h2, 2, 2, 0));
        tick_and_check("beq_wrap_load");

        // j 0x0AB
        idle();
        InstrD = 32'h080000AB; PCPlus4D = 9'h040;
        #1;
        chk("j_pcsrc", 32'(PCSrcD), 32'd1);
        chk("j_target", 32'(PCBranchD), 32'h0AB);
        chk("j_branchd", 32'(BranchD), 32'd0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 32'hAB, 0, 0, 0));
        tick_and_check("j_load");

        // Flush beats stall with lw in D
        FlushE = 1'b1; StallD = 1'b1;
        InstrD = itype(6'h23, 5'd1, 5'd4, 16'h0010); PCPlus4D = 9'h041;
        exp_q.push_back(BUBBLE);
        tick_and_check("flush_stall_bubble");

        idle();
        exp_q.push_back(mk(1, 1, 0, 1, 0, 4'b0010, 7, 0, 32'h10, 1, 4, 0));
        tick_and_check("lw_load");

        InstrD = itype(6'h2B, 5'd2, 5'd1, 16'hFFF0);
        exp_q.push_back(mk(0, 0, 1, 1, 0, 4'b0010, 9, 7, 32'hFFFFFFF0, 2, 1, 5'h1F));
        tick_and_check("sw_load");

        InstrD = itype(6'h0D, 5'd0, 5'd6, 16'h8000);
        exp_q.push_back(mk(1, 0, 0, 1, 0, 4'b0001, 0, 0, 32'h00008000, 0, 6, 5'h10));
        tick_and_check("ori_zero_ext");

        InstrD = itype(6'h08, 5'd0, 5'd6, 16'h8000);
        exp_q.push_back(mk(1, 0, 0, 1, 0, 4'b0010, 0, 0, 32'hFFFF8000, 0, 6, 5'h10));
        tick_and_check("addi_sign_ext");

        InstrD = itype(6'h0C, 5'd1, 5'd8, 16'hF0F0);
        exp_q.push_back(mk(1, 0, 0, 1, 0, 4'b0000, 7, 0, 32'h0000F0F0, 1, 8, 5'h1E));
        tick_and_check("andi_zero_ext");

        InstrD = {6'h3F, 5'd1, 5'd2, 16'h1234};
        exp_q.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 7, 9, 32'h1234, 1, 2, 2));
        tick_and_check("undefined_op_nop");

        InstrD = itype(6'h0F, 5'd0, 5'd3, 16'h00AB);
        exp_q.push_back(mk(1, 0, 0, 1, 0, 4'b1000, 0, 32'hDEADBEEF, 32'hAB, 0, 3, 0));
        tick_and_check("lui_load");

        InstrD = rtype(5'd1, 5'd2, 5'd7, 6'h2A);
        exp_q.push_back(mk(1, 0, 0, 0, 1, 4'b0111, 7, 9, 32'h382A, 1, 2, 7));
        tick_and_check("slt_load");

        InstrD = rtype(5'd1, 5'd2, 5'd7, 6'h27);
        exp_q.push_back(mk(1, 0, 0, 0, 1, 4'b1100, 7, 9, 32'h3827, 1, 2, 7));
        tick_and_check("nor_load");

        InstrD = rtype(5'd1, 5'd2, 5'd7, 6'h21);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 7, 9, 32'h3821, 1, 2, 7));
        tick_and_check("bad_funct_nop");

        // Mid-run reset clears the file and drops the concurrent writeback
        rst_n = 1'b0; RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'hAAAA;
        exp_q.push_back(BUBBLE);
        tick_and_check("midrun_reset_bubble");

        idle();
        InstrD = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        exp_q.push_back(mk(1, 0, 0, 0, 1, 4'b0010, 0, 0, 32'h1820, 1, 2, 3));
        tick_and_check("after_midrun_reset");

        checks++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
